// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with PC register, instruction-memory
// handshake, a one-entry skid buffer and the IF/ID pipeline register.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   stall                   decode holding; IF/ID not consumed this cycle
//   branch_taken/_target    redirect to branch_target (bits [1:0] forced 0)
//   jump/jump_index         redirect to {pc_out[31:28], jump_index, 2'b00}
//   imem_req/_addr          request to instruction memory (addr = PC)
//   imem_rdata/_ready       instruction memory response
//   instr/opcode/pc_out/valid  IF/ID register (pc_out = address + 4)
//   fetch_count/flush_count performance counters, present only when
//                           FETCH_PERF_CNT_EN is defined
//
// Configuration macro: FETCH_PERF_CNT_EN
//
// state | meaning
// IDLE  | no request; waits one cycle or while IF/ID is stalled and full
// FETCH | request outstanding at imem_addr; captures on imem_ready
// DRAIN | redirected with request in flight; waits out and drops response
// HOLD  | response parked in skid buffer until decode releases stall
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc_out,
  output logic        valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;          // next fetch address (already the new target in DRAIN)
  logic [31:0] addr_q;      // address on the bus; differs from pc only in DRAIN
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        ifid_free;

  assign redirect  = branch_taken | jump;
  assign target    = branch_taken ? (branch_target & 32'hFFFF_FFFC)
                                  : {pc_out[31:28], jump_index, 2'b00};
  assign pc_plus4  = pc + 32'd4;
  assign ifid_free = !stall || !valid;
  assign imem_addr = addr_q;
  assign opcode    = instr[31:26];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC & 32'hFFFF_FFFC;
      addr_q     <= RESET_PC & 32'hFFFF_FFFC;
      imem_req   <= 1'b0;
      instr      <= '0;
      pc_out     <= '0;
      valid      <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            pc     <= target;
            addr_q <= target;
            valid  <= 1'b0;
          end else begin
            if (!stall) valid <= 1'b0;
            if (!(stall && valid)) begin
              state    <= FETCH;
              imem_req <= 1'b1;
              addr_q   <= pc;
            end
          end
        end
        FETCH: begin
          if (redirect) begin
            pc    <= target;
            valid <= 1'b0;
            if (imem_ready) addr_q <= target;   // response dropped, refetch now
            else            state  <= DRAIN;    // bus still owes us a beat
          end else if (imem_ready) begin
            pc     <= pc_plus4;
            addr_q <= pc_plus4;
            if (ifid_free) begin
              instr  <= imem_rdata;
              pc_out <= pc_plus4;
              valid  <= 1'b1;
            end else begin
              skid_instr <= imem_rdata;
              skid_pc    <= pc_plus4;
              imem_req   <= 1'b0;
              state      <= HOLD;
            end
          end else if (!stall) begin
            valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (redirect) begin
            pc    <= target;
            valid <= 1'b0;
          end else if (!stall) begin
            valid <= 1'b0;
          end
          if (imem_ready) begin
            state  <= FETCH;
            addr_q <= redirect ? target : pc;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc       <= target;
            addr_q   <= target;
            valid    <= 1'b0;
            imem_req <= 1'b1;
            state    <= FETCH;
          end else if (!stall) begin
            instr  <= skid_instr;
            pc_out <= skid_pc;
            valid  <= 1'b1;
            state  <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic wr_ifid;

  // An instruction lands in IF/ID either straight from memory or out of the skid.
  assign wr_ifid = !redirect &&
                   (((state == FETCH) && imem_ready && ifid_free) ||
                    ((state == HOLD) && !stall));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (wr_ifid)  fetch_count <= fetch_count + 32'd1;
      if (redirect) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = '0;
  logic        imem_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc_out;
  logic        valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] flush_count;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] q[$];
  logic [31:0] exp_addr = '0;
  logic [31:0] e;

  // memory model: data word equals its address
  assign imem_rdata = imem_addr;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .instr(instr), .opcode(opcode), .pc_out(pc_out), .valid(valid)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({imem_req, valid} !== 2'b00) begin
      errors++; $display("FAIL reset_ctrl req=%b valid=%b want 0 0", imem_req, valid);
    end
    checks++;
    if ({instr, pc_out} !== 64'd0) begin
      errors++; $display("FAIL reset_ifid instr=%h pc_out=%h want 0 0", instr, pc_out);
    end
    checks++;
    if (imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_addr got %h want 0", imem_addr);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL reset_release_req got %b want 0", imem_req);
    end
    @(posedge clk); #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL first_req req=%b addr=%h want 1 0", imem_req, imem_addr);
    end
    exp_addr = 32'h0;
    imem_ready = 1'b1;
    q.push_back(exp_addr);
    exp_addr += 32'd4;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if ({valid, instr, pc_out} !== {1'b1, e, e + 32'd4}) begin
        errors++; $display("FAIL stream_ifid v=%b instr=%h pc_out=%h want instr %h", valid, instr, pc_out, e);
      end
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, exp_addr}) begin
        errors++; $display("FAIL stream_addr req=%b addr=%h want %h", imem_req, imem_addr, exp_addr);
      end
      if (i == 0) begin
        q.push_back(exp_addr);
        exp_addr += 32'd4;
      end else begin
        imem_ready = 1'b0;
      end
    end
  endtask

  task automatic test_wait();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h8}) begin
        errors++; $display("FAIL wait_hold v=%b req=%b addr=%h want 0 1 8", valid, imem_req, imem_addr);
      end
      if (k == 2) begin
        imem_ready = 1'b1;
        q.push_back(exp_addr);
        exp_addr += 32'd4;
      end
    end
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    if ({valid, instr, pc_out} !== {1'b1, e, e + 32'd4}) begin
      errors++; $display("FAIL wait_ifid v=%b instr=%h pc_out=%h want instr %h", valid, instr, pc_out, e);
    end
    checks++;
    if (imem_addr !== exp_addr) begin
      errors++; $display("FAIL wait_next_addr got %h want %h", imem_addr, exp_addr);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    q.push_back(exp_addr);      // goes to the skid buffer
    exp_addr += 32'd4;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({valid, instr, pc_out, imem_req} !== {1'b1, 32'h8, 32'hC, 1'b0}) begin
        errors++; $display("FAIL stall_hold v=%b instr=%h pc_out=%h req=%b want 1 8 c 0", valid, instr, pc_out, imem_req);
      end
    end
    stall = 1'b0;
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    if ({valid, instr, pc_out, imem_req} !== {1'b1, e, e + 32'd4, 1'b0}) begin
      errors++; $display("FAIL skid_release v=%b instr=%h pc_out=%h req=%b want instr %h", valid, instr, pc_out, imem_req, e);
    end
    @(posedge clk); #1;
    checks++;
    if ({valid, imem_req, imem_addr} !== {1'b0, 1'b1, exp_addr}) begin
      errors++; $display("FAIL stall_refetch v=%b req=%b addr=%h want 0 1 %h", valid, imem_req, imem_addr, exp_addr);
    end
    q.push_back(exp_addr);
    exp_addr += 32'd4;
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    if ({valid, instr, pc_out} !== {1'b1, e, e + 32'd4}) begin
      errors++; $display("FAIL stall_next_ifid v=%b instr=%h pc_out=%h want instr %h", valid, instr, pc_out, e);
    end
  endtask

  task automatic test_branch_drain();
    stall = 1'b1;               // redirect must override the stall
    imem_ready = 1'b0;
    branch_taken = 1'b1;
    branch_target = 32'h0000_0103;
    @(posedge clk); #1;
    checks++;
    if ({valid, imem_req, imem_addr} !== {1'b0, 1'b1, exp_addr}) begin
      errors++; $display("FAIL drain_enter v=%b req=%b addr=%h want 0 1 %h", valid, imem_req, imem_addr, exp_addr);
    end
    branch_taken = 1'b0;
    stall = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({valid, imem_req, imem_addr} !== {1'b0, 1'b1, exp_addr}) begin
      errors++; $display("FAIL drain_wait v=%b req=%b addr=%h want 0 1 %h", valid, imem_req, imem_addr, exp_addr);
    end
    imem_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100}) begin
      errors++; $display("FAIL drain_exit v=%b req=%b addr=%h want 0 1 100", valid, imem_req, imem_addr);
    end
    exp_addr = 32'h100;
    q.push_back(exp_addr);
    exp_addr += 32'd4;
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    if ({valid, instr, pc_out} !== {1'b1, e, e + 32'd4}) begin
      errors++; $display("FAIL branch_ifid v=%b instr=%h pc_out=%h want instr %h", valid, instr, pc_out, e);
    end
  endtask

  task automatic test_priority();
    branch_taken = 1'b1;
    branch_target = 32'h4000_000C;
    @(posedge clk); #1;
    checks++;
    if ({valid, imem_addr} !== {1'b0, 32'h4000_000C}) begin
      errors++; $display("FAIL redirect_ready v=%b addr=%h want 0 4000000c", valid, imem_addr);
    end
    branch_taken = 1'b0;
    exp_addr = 32'h4000_000C;
    q.push_back(exp_addr);
    exp_addr += 32'd4;
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    if ({valid, instr, pc_out} !== {1'b1, e, 32'h4000_0010}) begin
      errors++; $display("FAIL prio_setup v=%b instr=%h pc_out=%h want pc_out 40000010", valid, instr, pc_out);
    end
    branch_taken = 1'b1;
    branch_target = 32'h0000_0200;
    jump = 1'b1;
    jump_index = 26'h10;
    @(posedge clk); #1;
    checks++;
    if ({valid, imem_addr} !== {1'b0, 32'h0000_0200}) begin
      errors++; $display("FAIL branch_over_jump v=%b addr=%h want 0 200", valid, imem_addr);
    end
    branch_taken = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({valid, imem_addr} !== {1'b0, 32'h4000_0040}) begin
      errors++; $display("FAIL jump_target v=%b addr=%h want 0 40000040", valid, imem_addr);
    end
    jump = 1'b0;
    exp_addr = 32'h4000_0040;
    q.push_back(exp_addr);
    exp_addr += 32'd4;
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    if ({valid, instr, pc_out, opcode} !== {1'b1, e, e + 32'd4, 6'h10}) begin
      errors++; $display("FAIL jump_ifid v=%b instr=%h pc_out=%h opcode=%h want instr %h opcode 10", valid, instr, pc_out, opcode, e);
    end
  endtask

  task automatic test_drain_retarget();
    imem_ready = 1'b0;
    branch_taken = 1'b1;
    branch_target = 32'h0000_0300;
    @(posedge clk); #1;
    checks++;
    if ({valid, imem_req, imem_addr} !== {1'b0, 1'b1, exp_addr}) begin
      errors++; $display("FAIL retarget_drain v=%b req=%b addr=%h want 0 1 %h", valid, imem_req, imem_addr, exp_addr);
    end
    branch_taken = 1'b0;
    jump = 1'b1;
    jump_index = 26'h0C0;
    @(posedge clk); #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, exp_addr}) begin
      errors++; $display("FAIL retarget_hold req=%b addr=%h want 1 %h", imem_req, imem_addr, exp_addr);
    end
    jump = 1'b0;
    imem_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({valid, imem_addr} !== {1'b0, 32'h4000_0300}) begin
      errors++; $display("FAIL retarget_latest v=%b addr=%h want 0 40000300", valid, imem_addr);
    end
    exp_addr = 32'h4000_0300;
    q.push_back(exp_addr);
    exp_addr += 32'd4;
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    if ({valid, instr, pc_out} !== {1'b1, e, e + 32'd4}) begin
      errors++; $display("FAIL retarget_ifid v=%b instr=%h pc_out=%h want instr %h", valid, instr, pc_out, e);
    end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFF8;
    @(posedge clk); #1;
    checks++;
    if ({valid, imem_addr} !== {1'b0, 32'hFFFF_FFF8}) begin
      errors++; $display("FAIL wrap_start v=%b addr=%h want 0 fffffff8", valid, imem_addr);
    end
    branch_taken = 1'b0;
    exp_addr = 32'hFFFF_FFF8;
    q.push_back(exp_addr);
    exp_addr += 32'd4;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if ({valid, instr, pc_out, opcode} !== {1'b1, e, e + 32'd4, e[31:26]}) begin
        errors++; $display("FAIL wrap_ifid v=%b instr=%h pc_out=%h opcode=%h want instr %h", valid, instr, pc_out, opcode, e);
      end
      checks++;
      if (imem_addr !== exp_addr) begin
        errors++; $display("FAIL wrap_addr got %h want %h", imem_addr, exp_addr);
      end
      q.push_back(exp_addr);
      exp_addr += 32'd4;
    end
  endtask

  task automatic test_reset_mid();
    imem_ready = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req, valid, imem_addr, instr, pc_out} !== {2'b00, 96'd0}) begin
      errors++; $display("FAIL async_reset req=%b v=%b addr=%h instr=%h pc_out=%h want all 0", imem_req, valid, imem_addr, instr, pc_out);
    end
    q.delete();
    imem_ready = 1'b1;          // stale response around reset release
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h0}) begin
      errors++; $display("FAIL stale_ready v=%b req=%b addr=%h want 0 1 0", valid, imem_req, imem_addr);
    end
    exp_addr = 32'h0;
    q.push_back(exp_addr);
    exp_addr += 32'd4;
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    if ({valid, instr, pc_out} !== {1'b1, e, e + 32'd4}) begin
      errors++; $display("FAIL post_reset_ifid v=%b instr=%h pc_out=%h want instr %h", valid, instr, pc_out, e);
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    imem_ready = 1'b1;
    @(posedge clk);             // IDLE -> FETCH
    repeat (5) @(posedge clk);  // five captures
    #1;
    imem_ready = 1'b0;
    branch_taken = 1'b1;
    branch_target = 32'h80;
    repeat (2) @(posedge clk);  // two redirect edges
    #1;
    branch_taken = 1'b0;
    checks++;
    if ({fetch_count, flush_count} !== {32'd5, 32'd2}) begin
      errors++; $display("FAIL perf_counts fetch=%0d flush=%0d want 5 2", fetch_count, flush_count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fetch_count, flush_count} !== 64'd0) begin
      errors++; $display("FAIL perf_reset fetch=%0d flush=%0d want 0 0", fetch_count, flush_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_wait();
    test_stall();
    test_branch_drain();
    test_priority();
    test_drain_retarget();
    test_wrap();
    test_reset_mid();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
